// File: rtl/pic_pkg.sv
// Shared definitions for the PIC interrupt sequencer: sequencer states,
// level constants and the lowest-index-wins priority helper.
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam int LVL_W   = 3;

  // Level reported to the CPU when the request vanished at acknowledge time.
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_t;

  typedef struct packed {
    logic             found;
    logic [LVL_W-1:0] idx;
  } prio_t;

  // Lowest set index of v (IR0 is highest priority) plus a found flag.
  function automatic prio_t prio_idx(input logic [NUM_IRQ-1:0] v);
    prio_t r;
    r.found = 1'b0;
    r.idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = LVL_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_prio_enc8.sv
// Combinational 8-to-3 priority encoder; bit 0 is the highest priority.
module pic_prio_enc8
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [LVL_W-1:0]   idx,
  output logic               valid
);

  // Pick the lowest set request bit.
  always_comb begin
    prio_t p;
    p     = prio_idx(req);
    idx   = p.idx;
    valid = p.found;
  end

endmodule

// File: rtl/pic_int_sequencer.sv
// Interrupt-acknowledge sequencer and in-service arbiter for the 8259-style
// PIC. Runs the two-pulse INTA protocol, owns the ISR and handles EOIs.
// Optional build macro: PIC_AUTO_EOI_EN clears the in-service bit on the
// trailing edge of the second INTA pulse.
//
// Handshake: inta_n is sampled every clk; its falling/rising edges (against
// the one-cycle history inta_d) advance the sequencer. eoi_valid is a
// one-cycle strobe with no backpressure. clr_irr and data_oe are registered
// and qualify their companion values in the cycle they are high.
module pic_int_sequencer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [4:0]         vector_base,
  input  logic               inta_n,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [LVL_W-1:0]   eoi_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] clr_irr,
  output logic [7:0]         data_out,
  output logic               data_oe,
  output state_t             state_dbg
);

  state_t             state;
  logic               inta_d;
  logic [LVL_W-1:0]   lvl_q;

  logic [NUM_IRQ-1:0] pending;
  logic [LVL_W-1:0]   win;
  logic               pend_v;
  logic [LVL_W-1:0]   isr_top;
  logic               isr_v;
  logic               eligible;
  logic               fall;
  logic               rise;
  logic [NUM_IRQ-1:0] eoi_clr;
  logic [NUM_IRQ-1:0] isr_set;
  logic [NUM_IRQ-1:0] isr_auto;
  logic [NUM_IRQ-1:0] isr_next;

  assign pending   = irr & ~imr;
  assign state_dbg = state;

  pic_prio_enc8 u_pend_enc (
    .req   (pending),
    .idx   (win),
    .valid (pend_v)
  );

  pic_prio_enc8 u_isr_enc (
    .req   (isr),
    .idx   (isr_top),
    .valid (isr_v)
  );

  // A request may interrupt only a strictly lower-priority service routine.
  assign eligible = pend_v && (!isr_v || (win < isr_top));
  assign fall     = inta_d & ~inta_n;
  assign rise     = ~inta_d & inta_n;

  // ISR update masks: EOI clear, acknowledge set, optional automatic clear.
  always_comb begin
    eoi_clr  = '0;
    isr_set  = '0;
    isr_auto = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clr[eoi_level] = 1'b1;
      end else if (isr_v) begin
        eoi_clr[isr_top] = 1'b1;
      end
    end
    if ((state == REQ) && fall && eligible) begin
      isr_set[win] = 1'b1;
    end
`ifdef PIC_AUTO_EOI_EN
    if ((state == ACK2) && rise) begin
      isr_auto[lvl_q] = 1'b1;
    end
`else
    isr_auto = '0;
`endif
    // A set from the acknowledge overrides a same-cycle clear of that bit.
    isr_next = (isr & ~eoi_clr & ~isr_auto) | isr_set;
  end

  // Sequencer FSM with registered outputs and the ISR register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inta_d   <= 1'b1;
      lvl_q    <= '0;
      isr      <= '0;
      clr_irr  <= '0;
      int_out  <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      inta_d  <= inta_n;
      isr     <= isr_next;
      clr_irr <= '0;
      case (state)
        IDLE: begin
          int_out <= 1'b0;
          if (eligible) begin
            state   <= REQ;
            int_out <= 1'b1;
          end
        end
        REQ: begin
          if (fall) begin
            lvl_q   <= eligible ? win : SPURIOUS_LVL;
            clr_irr <= isr_set;
            state   <= ACK1;
          end else if (!eligible) begin
            int_out <= 1'b0;
            state   <= IDLE;
          end
        end
        ACK1: begin
          if (rise) state <= GAP;
        end
        GAP: begin
          if (fall) begin
            data_out <= {vector_base, lvl_q};
            data_oe  <= 1'b1;
            state    <= ACK2;
          end
        end
        ACK2: begin
          if (rise) begin
            data_oe  <= 1'b0;
            data_out <= '0;
            int_out  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Self-checking bench for pic_int_sequencer: directed scenarios followed by
// randomized acknowledge/EOI traffic against a transaction-level ISR model.
module tb_pic_int_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       inta_n;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [7:0] data_out;
  logic       data_oe;
  state_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference in-service set as the CPU would see it.
  logic [7:0] m_isr = 8'h00;

  pic_int_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .irr          (irr),
    .imr          (imr),
    .vector_base  (vector_base),
    .inta_n       (inta_n),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .int_out      (int_out),
    .isr          (isr),
    .clr_irr      (clr_irr),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .state_dbg    (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: highest-priority unmasked request, or -1 if none.
  function automatic int model_win(input logic [7:0] r, input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (r[i] && !m[i]) return i;
    return -1;
  endfunction

  // Highest-priority level in service, or 8 when nothing is in service.
  function automatic int model_top(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 8;
  endfunction

  function automatic bit model_elig(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
    int w;
    w = model_win(r, m);
    return (w >= 0) && (w < model_top(s));
  endfunction

  // Driver: one full request/acknowledge transaction.
  task automatic do_ack(input logic [7:0] irr_v, input logic [7:0] imr_v,
                        input bit withdraw, input bit eoi_same, input bit abort_gap);
    int         w;
    bit         elig;
    logic [2:0] lvl;
    logic [7:0] set_m;
    irr  = irr_v;
    imr  = imr_v;
    w    = model_win(irr_v, imr_v);
    elig = model_elig(irr_v, imr_v, m_isr);
    step();
    check_eq("int_req", 32'(int_out), 32'(elig));
    if (!elig) begin
      irr = 8'h00;
      step();
      return;
    end
    inta_n = 1'b0;
    if (withdraw) irr = 8'h00;
    if (eoi_same) begin
      eoi_valid    = 1'b1;
      eoi_specific = 1'b1;
      eoi_level    = 3'(w);
    end
    step();
    eoi_valid = 1'b0;
    if (withdraw) begin
      lvl   = 3'd7;
      set_m = 8'h00;
    end else begin
      lvl   = 3'(w);
      set_m = 8'(1 << w);
    end
    m_isr = m_isr | set_m;
    check_eq("isr_after_fall", 32'(isr), 32'(m_isr));
    check_eq("clr_irr_pulse", 32'(clr_irr), 32'(set_m));
    check_eq("int_held_ack1", 32'(int_out), 32'd1);
    check_eq("no_data_ack1", 32'(data_oe), 32'd0);
    irr = irr & ~set_m;
    step();
    check_eq("clr_irr_one_cycle", 32'(clr_irr), 32'd0);
    inta_n = 1'b1;
    step();
    check_eq("no_data_gap", 32'(data_oe), 32'd0);
    if (abort_gap) begin
      irr = 8'h00;
      rst = 1'b1;
      step();
      rst   = 1'b0;
      m_isr = 8'h00;
      check_eq("abort_int", 32'(int_out), 32'd0);
      check_eq("abort_isr", 32'(isr), 32'd0);
      check_eq("abort_clr", 32'(clr_irr), 32'd0);
      check_eq("abort_data", 32'(data_out), 32'd0);
      check_eq("abort_oe", 32'(data_oe), 32'd0);
      check_eq("abort_state", 32'(state_dbg), 32'(IDLE));
      return;
    end
    step();
    inta_n = 1'b0;
    step();
    check_eq("vec_oe", 32'(data_oe), 32'd1);
    check_eq("vec_data", 32'(data_out), 32'({vector_base, lvl}));
    check_eq("int_held_ack2", 32'(int_out), 32'd1);
    step();
    check_eq("vec_oe_hold", 32'(data_oe), 32'd1);
    inta_n = 1'b1;
    step();
`ifdef PIC_AUTO_EOI_EN
    m_isr = m_isr & ~(8'(1 << lvl));
`endif
    check_eq("oe_off_rise", 32'(data_oe), 32'd0);
    check_eq("int_off_rise", 32'(int_out), 32'd0);
    check_eq("isr_after_rise", 32'(isr), 32'(m_isr));
    irr = 8'h00;
    step();
    check_eq("rearm_gap", 32'(int_out), 32'd0);
  endtask

  // Driver: one EOI strobe with the model update.
  task automatic do_eoi(input bit spec, input logic [2:0] lvl);
    int top;
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    step();
    eoi_valid = 1'b0;
    if (spec) begin
      m_isr[lvl] = 1'b0;
    end else begin
      top = model_top(m_isr);
      if (top < 8) m_isr[top] = 1'b0;
    end
    check_eq(spec ? "eoi_specific" : "eoi_nonspecific", 32'(isr), 32'(m_isr));
  endtask

  initial begin
    rst          = 1'b1;
    irr          = 8'h00;
    imr          = 8'h00;
    vector_base  = 5'h10;
    inta_n       = 1'b1;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_int", 32'(int_out), 32'd0);
    check_eq("rst_isr", 32'(isr), 32'd0);
    check_eq("rst_clr", 32'(clr_irr), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_oe", 32'(data_oe), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));

    // Masked request stays quiet until the mask is lifted.
    irr = 8'h10;
    imr = 8'h10;
    step();
    check_eq("masked_quiet", 32'(int_out), 32'd0);
    step();
    check_eq("masked_quiet2", 32'(int_out), 32'd0);
    imr = 8'h00;
    step();
    check_eq("unmask_raise", 32'(int_out), 32'd1);
    irr = 8'h00;
    step();
    check_eq("withdraw_before_ack", 32'(int_out), 32'd0);
    step();

    // Basic acknowledge of IR3 with vector base 0x10.
    vector_base = 5'h10;
    do_ack(8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    // IR0 nests over IR3, then a non-specific EOI retires it.
    do_ack(8'h21, 8'h00, 1'b0, 1'b0, 1'b0);
    do_eoi(1'b0, 3'd0);
    // Request withdrawn in the same cycle as the first fall.
    do_ack(8'h04, 8'h00, 1'b1, 1'b0, 1'b0);
    // Clear IR3 then acknowledge it with a colliding specific EOI.
    do_eoi(1'b1, 3'd3);
    do_ack(8'h08, 8'h00, 1'b0, 1'b1, 1'b0);
    // Reset while waiting between the two pulses.
    do_ack(8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    step();

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      vector_base = 5'($urandom_range(0, 31));
      do_ack(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
             ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        do_eoi($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
